// File: rtl/axi4_sreg_master_pkg.sv
// Shared types for the single-beat AXI4 register master.
//   state_e       : master FSM states
//   OKAY..DECERR  : AXI response codes
//   BURST_INCR    : AXI burst encoding for INCR
//   wdog_state()  : states in which the watchdog counts
package axi4_sreg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  // States that wait on the slave; RSP and IDLE wait on our own client.
  function automatic logic wdog_state(state_e s);
    return (s == WR) || (s == WR_RESP) || (s == RD_ADDR) || (s == RD_DATA);
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 interface bundle (all five channels, no user/region signals).
//   master modport : drives AW/W/AR payload+valid, B/R ready
//   slave  modport : the mirror image
interface axi4_if #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi4_sreg_watchdog.sv
// Per-state cycle counter with a sticky timeout flag.
//   clk_i, rst_n : clock, async active-low reset
//   cnt_clr      : restart the count (entering a watched state)
//   cnt_en       : currently in a watched state
//   flag_clr     : new request accepted, drop the sticky flag
//   timeout_o    : set once the count reaches TIMEOUT_CYCLES, sticky
module axi4_sreg_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic cnt_clr,
  input  logic cnt_en,
  input  logic flag_clr,
  output logic timeout_o
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic          to_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      if (cnt_clr)                        cnt_q <= '0;
      else if (cnt_en && cnt_q != LIMIT)  cnt_q <= cnt_q + 1'b1;
      // Flag rises together with the count reaching LIMIT.
      if (flag_clr)                           to_q <= 1'b0;
      else if (cnt_en && cnt_q == LIMIT - 1'b1) to_q <= 1'b1;
    end
  end

  assign timeout_o = to_q;

endmodule

// File: rtl/axi4_sreg_master.sv
// Single-beat AXI4 initiator: turns one valid/ready register request into
// one AXI4 read or write and returns data/status on a response channel.
//   clk_i, rst_n       : clock, async active-low reset
//   m                  : AXI4 master port
//   req_*              : request channel (valid/ready, write, addr, wdata, wstrb)
//   rsp_*              : response channel (valid/ready, rdata, resp, err)
//   timeout_o          : sticky watchdog flag, only with AXI4_SREG_MASTER_TIMEOUT_EN
module axi4_sreg_master
  import axi4_sreg_pkg::*;
#(
  parameter int unsigned             AXI_ID_WIDTH   = 4,
  parameter int unsigned             AXI_ADDR_WIDTH = 32,
  parameter int unsigned             AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ID_WIDTH-1:0] MASTER_ID      = '0,
  parameter int unsigned             TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_n,
  axi4_if.master                      m,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_err
`ifdef AXI4_SREG_MASTER_TIMEOUT_EN
  ,
  output logic                        timeout_o
`endif
);
  localparam int unsigned ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [2:0]  AX_SIZE  = 3'(ADDR_LSB);
  localparam logic [AXI_ADDR_WIDTH-1:0] LSB_MASK = AXI_ADDR_WIDTH'((1 << ADDR_LSB) - 1);

  state_e                      state_q, state_d;
  logic                        armed_q;
  logic                        aw_done_q, w_done_q;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic [1:0]                  resp_q;
  logic                        err_q;

  logic awvalid, wvalid, bready, arvalid, rready;
  logic accept, b_hs, r_hs;

  // All valids come from registered state only, never from the matching ready.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        // armed_q keeps req_ready low through reset and its first cycle out.
        req_ready = armed_q;
        if (req_valid && armed_q) state_d = req_write ? WR : RD_ADDR;
      end
      WR: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if ((aw_done_q || m.awready) && (w_done_q || m.wready)) state_d = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (m.bvalid) state_d = RSP;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (m.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (m.rvalid) state_d = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;
  assign b_hs   = bready && m.bvalid;
  assign r_hs   = rready && m.rvalid;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= OKAY;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (accept) begin
        addr_q    <= req_addr & ~LSB_MASK;
        wdata_q   <= req_wdata;
        wstrb_q   <= req_wstrb;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (awvalid && m.awready) aw_done_q <= 1'b1;
      if (wvalid && m.wready)   w_done_q  <= 1'b1;
      if (b_hs) begin
        rdata_q <= '0;
        resp_q  <= m.bresp;
        err_q   <= (m.bid != MASTER_ID);
      end
      if (r_hs) begin
        rdata_q <= m.rdata;
        resp_q  <= m.rresp;
        err_q   <= (m.rid != MASTER_ID) || !m.rlast;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign rsp_err   = err_q;

  // Fixed single-beat INCR attributes.
  assign m.awid    = MASTER_ID;
  assign m.awaddr  = addr_q;
  assign m.awlen   = 8'd0;
  assign m.awsize  = AX_SIZE;
  assign m.awburst = BURST_INCR;
  assign m.awlock  = 1'b0;
  assign m.awcache = 4'd0;
  assign m.awprot  = 3'd0;
  assign m.awqos   = 4'd0;
  assign m.awvalid = awvalid;
  assign m.wdata   = wdata_q;
  assign m.wstrb   = wstrb_q;
  assign m.wlast   = 1'b1;
  assign m.wvalid  = wvalid;
  assign m.bready  = bready;
  assign m.arid    = MASTER_ID;
  assign m.araddr  = addr_q;
  assign m.arlen   = 8'd0;
  assign m.arsize  = AX_SIZE;
  assign m.arburst = BURST_INCR;
  assign m.arlock  = 1'b0;
  assign m.arcache = 4'd0;
  assign m.arprot  = 3'd0;
  assign m.arqos   = 4'd0;
  assign m.arvalid = arvalid;
  assign m.rready  = rready;

`ifdef AXI4_SREG_MASTER_TIMEOUT_EN
  axi4_sreg_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .cnt_clr  (wdog_state(state_d) && (state_d != state_q)),
    .cnt_en   (wdog_state(state_q)),
    .flag_clr (accept),
    .timeout_o(timeout_o)
  );
`endif

endmodule

// File: tb/tb_axi4_sreg_master.sv
// Directed bench for axi4_sreg_master with a small behavioural AXI slave
// (register file, configurable ready delays and response fields) and a
// scoreboard queue of expected responses.
module tb_axi4_sreg_master;
  import axi4_sreg_pkg::*;

  localparam logic [3:0]  MID     = 4'h3;
  localparam logic [31:0] CORE0_ID = 32'hC0DE_0001;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        err;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
`ifdef AXI4_SREG_MASTER_TIMEOUT_EN
  logic        timeout_o;
`endif

  axi4_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) axi ();

  axi4_sreg_master #(
    .AXI_ID_WIDTH(4), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32),
    .MASTER_ID(MID), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n), .m(axi),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_err(rsp_err)
`ifdef AXI4_SREG_MASTER_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // ---------------- slave configuration ----------------
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  logic [3:0]  b_bid = MID, r_id = MID;
  logic [1:0]  b_resp = OKAY;
  logic        r_last = 1'b1;

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // ---------------- behavioural slave ----------------
  int          aw_wait, w_wait, ar_wait, r_cnt;
  logic        aw_seen, w_seen, b_arm, r_pend, bvalid_q, rvalid_q;
  logic [3:0]  wr_idx, rd_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] mem [16];
  bit          mem_init = 1'b0;

  wire aw_hs = axi.awvalid && axi.awready;
  wire w_hs  = axi.wvalid && axi.wready;
  wire ar_hs = axi.arvalid && axi.arready;

  assign axi.awready = axi.awvalid && (aw_wait >= aw_dly);
  assign axi.wready  = axi.wvalid && (w_wait >= w_dly);
  assign axi.arready = axi.arvalid && (ar_wait >= ar_dly);
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = b_bid;
  assign axi.bresp   = b_resp;
  assign axi.rvalid  = rvalid_q;
  assign axi.rid     = r_id;
  assign axi.rdata   = mem[rd_idx];
  assign axi.rresp   = OKAY;
  assign axi.rlast   = r_last;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_cnt <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; b_arm <= 1'b0; r_pend <= 1'b0;
      bvalid_q <= 1'b0; rvalid_q <= 1'b0;
      wr_idx <= '0; rd_idx <= '0; wr_data <= '0; wr_strb <= '0;
    end else begin
      aw_wait <= (axi.awvalid && !axi.awready) ? aw_wait + 1 : 0;
      w_wait  <= (axi.wvalid && !axi.wready) ? w_wait + 1 : 0;
      ar_wait <= (axi.arvalid && !axi.arready) ? ar_wait + 1 : 0;
      if (aw_hs) begin aw_seen <= 1'b1; wr_idx <= axi.awaddr[5:2]; end
      if (w_hs)  begin w_seen <= 1'b1; wr_data <= axi.wdata; wr_strb <= axi.wstrb; end
      // B goes out one cycle after the write is committed.
      if ((aw_seen || aw_hs) && (w_seen || w_hs)) begin
        b_arm <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
      end
      if (b_arm) begin b_arm <= 1'b0; bvalid_q <= 1'b1; end
      if (bvalid_q && axi.bready) bvalid_q <= 1'b0;
      if (ar_hs) begin
        rd_idx <= axi.araddr[5:2];
        if (r_dly == 0) rvalid_q <= 1'b1;
        else begin r_pend <= 1'b1; r_cnt <= r_dly - 1; end
      end else if (r_pend) begin
        if (r_cnt == 0) begin rvalid_q <= 1'b1; r_pend <= 1'b0; end
        else r_cnt <= r_cnt - 1;
      end
      if (rvalid_q && axi.rready) rvalid_q <= 1'b0;
    end
  end

  always @(posedge clk_i) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 1) ? CORE0_ID : 32'hA000_0000 + 32'(i);
      mem_init <= 1'b1;
    end else if (b_arm) begin
      mem[wr_idx] <= merge(mem[wr_idx], wr_data, wr_strb);
    end
  end

  // ---------------- bus monitor ----------------
  int          cyc = 0, aw_beats = 0, w_beats = 0, aw_cyc = 0, w_cyc = 0;
  logic [31:0] aw_addr_seen, ar_addr_seen;
  logic [7:0]  aw_len_seen, ar_len_seen;
  logic [2:0]  aw_size_seen, ar_size_seen;
  logic [1:0]  aw_burst_seen;
  logic [3:0]  aw_id_seen;
  logic        wlast_seen;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (aw_hs) begin
      aw_addr_seen <= axi.awaddr; aw_len_seen <= axi.awlen; aw_size_seen <= axi.awsize;
      aw_burst_seen <= axi.awburst; aw_id_seen <= axi.awid;
      aw_beats <= aw_beats + 1; aw_cyc <= cyc;
    end
    if (w_hs) begin wlast_seen <= axi.wlast; w_beats <= w_beats + 1; w_cyc <= cyc; end
    if (ar_hs) begin
      ar_addr_seen <= axi.araddr; ar_len_seen <= axi.arlen; ar_size_seen <= axi.arsize;
    end
  end

  // ---------------- checking ----------------
  int   n_chk = 0, n_fail = 0;
  exp_t sb[$];
  logic [31:0] model [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request and return right after the accepting clock edge.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st);
    @(negedge clk_i);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = st;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk_i);
    chk("req_accept_wait", {63'd0, req_ready}, 64'd1);
    @(posedge clk_i);
    #1 req_valid = 1'b0;
  endtask

  // Expected response pushed at issue time from the bench's own model.
  task automatic push_exp(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] st);
    exp_t e;
    if (wr) begin
      e.rdata = '0; e.resp = b_resp; e.err = (b_bid != MID);
      model[addr[5:2]] = merge(model[addr[5:2]], wd, st);
    end else begin
      e.rdata = model[addr[5:2]]; e.resp = OKAY; e.err = (r_id != MID) || !r_last;
    end
    sb.push_back(e);
  endtask

  task automatic wait_rsp(input int hold, output int lat);
    exp_t        e;
    logic [31:0] first;
    lat = 0;
    do begin @(negedge clk_i); lat++; end while (!rsp_valid && lat < 200);
    chk("rsp_valid_wait", {63'd0, rsp_valid}, 64'd1);
    first = rsp_rdata;
    for (int k = 0; k < hold; k++) begin
      chk("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("hold_rsp_rdata", {32'd0, rsp_rdata}, {32'd0, first});
      chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clk_i);
    end
    e = sb.pop_front();
    chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
    chk("rsp_resp",  {62'd0, rsp_resp},  {62'd0, e.resp});
    chk("rsp_err",   {63'd0, rsp_err},   {63'd0, e.err});
    rsp_ready = 1'b1;
    @(negedge clk_i);
    rsp_ready = 1'b0;
    if (hold > 0) begin
      chk("post_hs_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("post_hs_req_ready", {63'd0, req_ready}, 64'd1);
    end
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input int hold, output int lat);
    push_exp(wr, addr, wd, st);
    issue(wr, addr, wd, st);
    wait_rsp(hold, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: run did not reach summary");
    $fatal(1, "global timeout");
  end

  initial begin
    int lat, n;
    for (int i = 0; i < 16; i++) model[i] = (i == 1) ? CORE0_ID : 32'hA000_0000 + 32'(i);
    repeat (3) @(negedge clk_i);

    // Reset state
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("rst_rsp_resp",  {62'd0, rsp_resp},  64'd0);
    chk("rst_rsp_err",   {63'd0, rsp_err},   64'd0);
    chk("rst_valids", {59'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 64'd0);
    rst_n = 1'b1;

    // Write 0x0C, AWREADY two cycles ahead of WREADY
    w_dly = 2;
    do_req(1'b1, 32'h0C, 32'h1, 4'hF, 0, lat);
    chk("t1_awaddr", {32'd0, aw_addr_seen}, 64'h0C);
    chk("t1_awlen",  {56'd0, aw_len_seen}, 64'd0);
    chk("t1_awsize", {61'd0, aw_size_seen}, 64'd2);
    chk("t1_awburst", {62'd0, aw_burst_seen}, 64'd1);
    chk("t1_awid",   {60'd0, aw_id_seen}, {60'd0, MID});
    chk("t1_wlast",  {63'd0, wlast_seen}, 64'd1);
    chk("t1_beats",  64'(aw_beats * 16 + w_beats), 64'd17);
    chk("t1_w_gap",  64'(w_cyc - aw_cyc), 64'd2);
    w_dly = 0;

    // Zero-wait write with partial strobes
    do_req(1'b1, 32'h12, 32'hDEAD_BEEF, 4'h5, 0, lat);
    chk("wr_latency", 64'(lat), 64'd4);
    chk("wr_awaddr_align", {32'd0, aw_addr_seen}, 64'h10);

    // Read unaligned 0x06 from the core-info register
    do_req(1'b0, 32'h06, 32'h0, 4'h0, 0, lat);
    chk("t2_araddr", {32'd0, ar_addr_seen}, 64'h04);
    chk("t2_arlen",  {56'd0, ar_len_seen}, 64'd0);
    chk("t2_arsize", {61'd0, ar_size_seen}, 64'd2);
    chk("rd_latency", 64'(lat), 64'd3);

    // Read back with the response held off for 5 cycles
    do_req(1'b0, 32'h0C, 32'h0, 4'h0, 5, lat);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, lat);

    // Write answered with wrong BID and SLVERR
    b_bid = MID + 4'd1; b_resp = SLVERR;
    do_req(1'b1, 32'h1C, 32'h5555_AAAA, 4'hF, 0, lat);
    b_bid = MID; b_resp = OKAY;

    // Read without RLAST, then with a wrong RID
    r_last = 1'b0;
    do_req(1'b0, 32'h08, 32'h0, 4'h0, 0, lat);
    r_last = 1'b1; r_id = MID ^ 4'h8;
    do_req(1'b0, 32'h08, 32'h0, 4'h0, 0, lat);
    r_id = MID;

    // Reset while waiting in RD_DATA
    r_dly = 50;
    issue(1'b0, 32'h08, 32'h0, 4'h0);
    n = 0;
    while (!axi.rready && n < 20) begin @(negedge clk_i); n++; end
    chk("t5_in_rd_data", {63'd0, axi.rready}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_arvalid", {63'd0, axi.arvalid}, 64'd0);
    chk("t5_rready",  {63'd0, axi.rready}, 64'd0);
    chk("t5_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("t5_req_ready", {63'd0, req_ready}, 64'd0);
    @(negedge clk_i);
    rst_n = 1'b1; r_dly = 0;
    do_req(1'b0, 32'h04, 32'h0, 4'h0, 0, lat);
    chk("t5_after_latency", 64'(lat), 64'd3);

`ifdef AXI4_SREG_MASTER_TIMEOUT_EN
    // ARREADY held low for 20 cycles with a 16-cycle watchdog
    ar_dly = 20;
    push_exp(1'b0, 32'h04, 32'h0, 4'h0);
    issue(1'b0, 32'h04, 32'h0, 4'h0);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk_i);
      if (k == 16) chk("t6_timeout_low", {63'd0, timeout_o}, 64'd0);
      if (k == 17) chk("t6_timeout_high", {63'd0, timeout_o}, 64'd1);
    end
    wait_rsp(0, lat);
    chk("t6_timeout_sticky", {63'd0, timeout_o}, 64'd1);
    ar_dly = 0;
    push_exp(1'b0, 32'h0C, 32'h0, 4'h0);
    issue(1'b0, 32'h0C, 32'h0, 4'h0);
    @(negedge clk_i);
    chk("t6_timeout_cleared", {63'd0, timeout_o}, 64'd0);
    wait_rsp(0, lat);
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
